// File: rtl/serial_minuend_restorer_pkg.sv
// Shared types and helpers for the bit-serial minuend restorer.
//   restorer_state_t : IDLE -> RUN -> DONE -> IDLE control states
//   DEFAULT_WIDTH    : default operand/result width
//   cnt_width()      : width of the bit counter needed to count 0..n-1
package serial_minuend_restorer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } restorer_state_t;

    localparam int DEFAULT_WIDTH = 4;

    // Never narrower than one bit so the counter stays legal for tiny widths.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_minuend_restorer_adder.sv
// serial_full_adder_bit: one-bit combinational full adder used by the
// serial restorer. The carry flop lives in the parent.
// Ports:
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and carry-out
module serial_full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_minuend_restorer.sv
// serial_minuend_restorer: reconstructs the minuend A of an N-bit subtraction
// from its result (magnitude Difference, negative flag flagN) and the
// subtrahend B, one bit per clock, LSB first.
//   flagN=0 : A = Difference + B
//   flagN=1 : A = B - Difference = B + ~Difference + 1   (all mod 2^N)
// Ports:
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   start             : operand request, sampled only in IDLE
//   Difference, flagN : subtractor result being inverted
//   B                 : subtrahend of the original subtraction
//   busy              : high in RUN and DONE
//   valid, ready      : result handshake; result leaves on valid & ready
//   A                 : reconstructed minuend, meaningful while valid=1
//   err               : operands inconsistent (overflow / Difference > B)
// Optional build macro SERIAL_MINUEND_RESTORER_ERR_EN enables err; without
// it err is tied to 0.
module serial_minuend_restorer
    import serial_minuend_restorer_pkg::*;
#(
    parameter int N = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] Difference,
    input  logic         flagN,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         valid,
    input  logic         ready,
    output logic [N-1:0] A,
    output logic         err
);

    localparam int CW = cnt_width(N);

    restorer_state_t state_reg, state_next;

    logic [N-1:0]  d_sh_reg;
    logic [N-1:0]  b_sh_reg;
    logic [N-1:0]  a_reg;
    logic          flag_reg;
    logic          carry_reg;
    logic [CW-1:0] cnt_reg;

    logic sum_bit;
    logic carry_out;
    logic last_bit;

    assign last_bit = (cnt_reg == CW'(N - 1));

    // Subtraction case: inverting each Difference bit and seeding the carry
    // with 1 forms the two's complement on the fly.
    serial_full_adder_bit u_fa (
        .a    (d_sh_reg[0] ^ flag_reg),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .s    (sum_bit),
        .cout (carry_out)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (last_bit) state_next = DONE;
            DONE:    if (ready)    state_next = IDLE;
            default:               state_next = IDLE;
        endcase
    end

    // Datapath: operand latch, serial add, result shift
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_sh_reg  <= '0;
            b_sh_reg  <= '0;
            a_reg     <= '0;
            flag_reg  <= 1'b0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        d_sh_reg  <= Difference;
                        b_sh_reg  <= B;
                        flag_reg  <= flagN;
                        carry_reg <= flagN;
                        cnt_reg   <= '0;
                    end
                end
                RUN: begin
                    // Sum bits enter at the MSB; after N shifts bit 0 is the LSB.
                    a_reg     <= {sum_bit, a_reg[N-1:1]};
                    d_sh_reg  <= d_sh_reg >> 1;
                    b_sh_reg  <= b_sh_reg >> 1;
                    carry_reg <= carry_out;
                    cnt_reg   <= cnt_reg + CW'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_MINUEND_RESTORER_ERR_EN
    logic err_reg;

    // Addition must not carry out; subtraction must (no borrow).
    // Either mismatch means the operands could not have come from the subtractor.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (state_reg == RUN && last_bit) begin
            err_reg <= carry_out ^ flag_reg;
        end else if (state_reg == DONE && ready) begin
            err_reg <= 1'b0;
        end
    end

    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign busy  = (state_reg != IDLE);
    assign valid = (state_reg == DONE);
    assign A     = a_reg;

endmodule

// File: doc/serial_minuend_restorer.md
Name: serial_minuend_restorer

Overview:
- Bit-serial inverse of the team's N-bit subtractor.
- Inputs are a subtractor result (magnitude Difference plus negative flag) and the subtrahend B. The block reconstructs the minuend A over N clock cycles, LSB first.
- Used as a self-check / round-trip stage after the subtractor in the lab ALU datapath.
- Operands are accepted with start/busy; the result is returned with a valid/ready handshake.

Parameters:
- N, 4, operand/result width in bits (N >= 2)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- Difference  input  N  magnitude produced by subtractor
- flagN  input  1  negative flag from subtractor (1: original A < B)
- B  input  N  subtrahend used in original subtraction
- busy  output  1  high in RUN and DONE
- valid  output  1  result available (DONE)
- ready  input  1  consumer accepts result when valid & ready
- A  output  N  reconstructed minuend
- err  output  1  operands inconsistent (see Optional Feature)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, A=0, valid=0, busy=0, err=0, bit counter=0, carry=0, shift regs=0. Reset mid-RUN or mid-DONE aborts with no output.
- Arithmetic, mod 2^N:
  - flagN=0: A = Difference + B.
  - flagN=1: A = B - Difference = B + ~Difference + 1.
  - Serial form: carry seeded with flagN; each D bit XORed with the latched flagN before the full add.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE: on edge with start=1, latch Difference, B, flagN into shift regs; carry=flagN; cnt=0; go to RUN. start=0: stay.
  - RUN: each edge adds bit cnt; sum bit shifts into A from MSB side (A fully LSB-aligned after N shifts); carry updates; cnt++. On the edge where cnt==N-1, go to DONE and latch final carry-out.
  - DONE: valid=1; A and err held stable. Edge with ready=1 goes to IDLE with valid=0. ready=0 holds indefinitely.
- Latency: start accepted at edge k -> valid visible after edge k+N, i.e. exactly N cycles in RUN.
- start outside IDLE is ignored, including in DONE.
- A in RUN holds partial shift contents; it is only meaningful while valid=1.
- Input ports are ignored after latch; changing them during RUN has no effect.
- ready outside DONE is ignored.
- Back-to-back: handshake at edge j returns to IDLE; earliest next accept is edge j+1.

Optional Feature:
- Macro: SERIAL_MINUEND_RESTORER_ERR_EN.
- Defined: on entry to DONE, err = final_carry XOR flagN.
  - flagN=0 with carry-out means A overflowed N bits.
  - flagN=1 without carry-out means Difference > B.
  - err is held with valid and cleared on the IDLE transition.
- Undefined: err port still present, tied to 0; no carry-out register.

Decomposition:
- Package serial_minuend_restorer_pkg:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} restorer_state_t.
  - Localparam DEFAULT_WIDTH = 4.
  - Counter width function $clog2(N).
- Sub-module serial_full_adder_bit: combinational a, b, cin -> s, cout. Single instance; the carry flop stays in the parent.

Test Plan:
- N=4, Difference=3, flagN=0, B=5, start pulse, ready=1 -> A=8, err=0, valid high exactly 4 cycles after accept edge, busy low next cycle.
- Difference=2, flagN=1, B=7 -> A=5, err=0. Hold ready=0 for 10 cycles -> valid, A stable; ready=1 -> IDLE.
- Difference=9, flagN=0, B=9 -> A=2, err=1 (with ERR_EN); err=0 without macro.
- Difference=7, flagN=1, B=3 -> A=12, err=1 (with ERR_EN).
- Start pulses during RUN and DONE, inputs toggled mid-RUN -> ignored; result matches first latched operands.
- rst_n low at RUN cycle 2 -> A=0, valid=0, busy=0 immediately (async); new start after release -> correct result after 4 cycles.
